// File: rtl/bus_master_if.sv
// Downstream master port toward the bus decoder: one-hot slave select with
// address/data/write-enable out, acknowledge and read data back.
interface bus_master_if;
   logic [31:0] m_addr_o;
   logic [31:0] m_data_o;
   logic        m_we_o;
   logic [15:0] m_select_o;
   logic [31:0] m_data_i;
   logic        m_ack_i;

   modport master (
      output m_addr_o, m_data_o, m_we_o, m_select_o,
      input  m_data_i, m_ack_i
   );

   modport slave (
      input  m_addr_o, m_data_o, m_we_o, m_select_o,
      output m_data_i, m_ack_i
   );
endinterface

// File: rtl/bus_master.sv
// Single-outstanding CPU-to-bus bridge: decodes the slave from addr[31:28],
// runs one select/ack transfer with a WAIT timeout, and reports done or error.
//
// state | meaning
// IDLE  | no transfer; a request is sampled here
// ISSUE | first select cycle, decoder latches select, ack ignored
// WAIT  | select held, waiting for ack or timeout
// RESP  | one-cycle completion pulse
// ERR   | one-cycle error pulse (unmapped slave or timeout)
module bus_master #(
   parameter int TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req_i,
   input  logic [31:0] cpu_addr_i,
   input  logic        cpu_we_i,
   input  logic [31:0] cpu_data_i,
   output logic [31:0] cpu_data_o,
   output logic        cpu_stall_o,
   output logic        cpu_done_o,
   output logic        cpu_err_o,
   bus_master_if.master m
);

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP,
      ERR
   } state_t;

   // The counter holds the number of WAIT cycles already completed, so the
   // last permitted WAIT cycle is the one that sees TIMEOUT-1.
   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   state_t      state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        we_q;
   logic [15:0] sel_q;
   logic [15:0] sel_dec;
   logic [7:0]  cnt_q;
   logic        mapped;
   logic        launch;
   logic        on_bus;
   logic        timeout_hit;

   always_comb begin
      sel_dec = '0;
      sel_dec[cpu_addr_i[31:28]] = 1'b1;
   end

   assign mapped      = ~cpu_addr_i[31];
   assign launch      = (state_q == IDLE) && cpu_req_i && mapped;
   assign on_bus      = (state_q == ISSUE) || (state_q == WAIT);
   assign timeout_hit = (cnt_q == WAIT_LAST);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         if (launch) begin
            addr_q  <= cpu_addr_i;
            wdata_q <= cpu_data_i;
            we_q    <= cpu_we_i;
            sel_q   <= sel_dec;
            cnt_q   <= '0;
         end else if (state_q == WAIT) begin
            cnt_q <= cnt_q + 8'd1;
         end
         if ((state_q == WAIT) && m.m_ack_i) begin
            if (!we_q) begin
               rdata_q <= m.m_data_i;
            end
         end else if (state_d == ERR) begin
            rdata_q <= '0;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      cpu_done_o  = 1'b0;
      cpu_err_o   = 1'b0;
      cpu_stall_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            cpu_stall_o = cpu_req_i;
            if (cpu_req_i) begin
               state_d = mapped ? ISSUE : ERR;
            end
         end
         ISSUE: begin
            cpu_stall_o = 1'b1;
            state_d     = WAIT;
         end
         WAIT: begin
            cpu_stall_o = 1'b1;
            if (m.m_ack_i) begin
               state_d = RESP;
            end else if (timeout_hit) begin
               state_d = ERR;
            end
         end
         RESP: begin
            cpu_done_o = 1'b1;
            state_d    = IDLE;
         end
         ERR: begin
            cpu_err_o = 1'b1;
            state_d   = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Bus outputs are gated by state so they drop to zero the instant the
   // transfer ends or an asynchronous reset hits.
   assign m.m_addr_o   = on_bus ? addr_q  : '0;
   assign m.m_data_o   = on_bus ? wdata_q : '0;
   assign m.m_we_o     = on_bus & we_q;
   assign m.m_select_o = on_bus ? sel_q   : '0;
   assign cpu_data_o   = rdata_q;

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master: a transaction-level timeline model drives the
// expected outputs and one negedge process compares them every cycle.
module tb_bus_master;
   localparam int TMO = 4;

   logic        clk;
   logic        rst;
   logic        cpu_req_i;
   logic [31:0] cpu_addr_i;
   logic        cpu_we_i;
   logic [31:0] cpu_data_i;
   logic [31:0] cpu_data_o;
   logic        cpu_stall_o;
   logic        cpu_done_o;
   logic        cpu_err_o;

   bus_master_if bus ();

   bus_master #(.TIMEOUT(TMO)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_req_i  (cpu_req_i),
      .cpu_addr_i (cpu_addr_i),
      .cpu_we_i   (cpu_we_i),
      .cpu_data_i (cpu_data_i),
      .cpu_data_o (cpu_data_o),
      .cpu_stall_o(cpu_stall_o),
      .cpu_done_o (cpu_done_o),
      .cpu_err_o  (cpu_err_o),
      .m          (bus)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   bit          check_en = 0;
   logic [31:0] exp_addr, exp_wdata, exp_data;
   logic [15:0] exp_sel;
   logic        exp_we, exp_stall, exp_done, exp_err;
   logic [31:0] model_rdata = 32'h0;

   int txn_start, done_cyc, err_cyc, issue_cyc, pulse_cnt, sel4_cnt, wr80_cnt;
   logic [15:0] prev_sel = 16'h0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      if (check_en) begin
         chk("cmp_m_addr",   bus.m_addr_o, exp_addr);
         chk("cmp_m_data",   bus.m_data_o, exp_wdata);
         chk("cmp_m_we",     {31'h0, bus.m_we_o}, {31'h0, exp_we});
         chk("cmp_m_select", {16'h0, bus.m_select_o}, {16'h0, exp_sel});
         chk("cmp_stall",    {31'h0, cpu_stall_o}, {31'h0, exp_stall});
         chk("cmp_done",     {31'h0, cpu_done_o}, {31'h0, exp_done});
         chk("cmp_err",      {31'h0, cpu_err_o}, {31'h0, exp_err});
         chk("cmp_cpu_data", cpu_data_o, exp_data);
      end
   end

   always @(negedge clk) begin
      if (cpu_done_o) done_cyc = cyc;
      if (cpu_err_o) err_cyc = cyc;
      if (cpu_done_o || cpu_err_o) pulse_cnt++;
      if (bus.m_select_o == 16'h0004) sel4_cnt++;
      if (bus.m_select_o == 16'h0080 && bus.m_we_o && bus.m_data_o == 32'h1234_5678) wr80_cnt++;
      if (bus.m_select_o != 16'h0 && prev_sel == 16'h0) issue_cyc = cyc;
      prev_sel = bus.m_select_o;
   end

   task automatic set_idle_exp();
      exp_addr  = '0;
      exp_wdata = '0;
      exp_we    = 1'b0;
      exp_sel   = '0;
      exp_stall = cpu_req_i;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      exp_data  = model_rdata;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         set_idle_exp();
         check_en = 1;
         @(posedge clk); #1;
      end
   endtask

   // Timeline of one request, cycle 0 being the IDLE cycle that samples it.
   // Mapped: select held for cycles 1..1+w, pulse in cycle 2+w, where w is the
   // WAIT cycle (1..TMO) carrying the first ack, or TMO on timeout.
   // Unmapped: error pulse in cycle 1, bus never selected.
   task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [15:0] ack_mask,
                          input bit drop_mid, input bit keep_req);
      bit          mapped;
      bit          acked;
      int          w;
      int          e;
      logic [15:0] onehot;
      bit          in_bus;
      mapped = (addr[31:28] < 4'd8);
      onehot = mapped ? (16'h1 << addr[31:28]) : 16'h0;
      acked  = 0;
      w      = TMO;
      if (mapped) begin
         for (int k = 1; k <= TMO; k++) begin
            if (ack_mask[k + 1]) begin
               w     = k;
               acked = 1;
               break;
            end
         end
      end
      e = mapped ? 2 + w : 1;
      txn_start  = cyc;
      cpu_req_i  = 1'b1;
      cpu_addr_i = addr;
      cpu_we_i   = we;
      cpu_data_i = wdata;
      for (int c = 0; c <= e; c++) begin
         bus.m_ack_i  = ack_mask[c];
         bus.m_data_i = ack_mask[c] ? rdata : ~rdata;
         if (c == e) begin
            if (mapped && acked) begin
               if (!we) model_rdata = rdata;
            end else begin
               model_rdata = 32'h0;
            end
         end
         in_bus    = mapped && (c >= 1) && (c <= 1 + w);
         exp_sel   = in_bus ? onehot : 16'h0;
         exp_addr  = in_bus ? addr : 32'h0;
         exp_wdata = in_bus ? wdata : 32'h0;
         exp_we    = in_bus && we;
         exp_stall = (c < e);
         exp_done  = (c == e) && mapped && acked;
         exp_err   = (c == e) && !(mapped && acked);
         exp_data  = model_rdata;
         check_en  = 1;
         @(posedge clk); #1;
         if (c < e) begin
            cpu_addr_i = $urandom;
            cpu_we_i   = ~we;
            cpu_data_i = $urandom;
            if (drop_mid && c >= 1) cpu_req_i = 1'b0;
         end
      end
      if (!keep_req) cpu_req_i = 1'b0;
      bus.m_ack_i  = 1'b1;
      bus.m_data_i = $urandom;
      set_idle_exp();
   endtask

   int d_first;
   int p0;

   initial begin
      rst          = 1'b0;
      cpu_req_i    = 1'b0;
      cpu_addr_i   = 32'h0;
      cpu_we_i     = 1'b0;
      cpu_data_i   = 32'h0;
      bus.m_ack_i  = 1'b1;
      bus.m_data_i = 32'h0;
      pulse_cnt    = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_m_select", {16'h0, bus.m_select_o}, 32'h0);
      chk("rst_m_addr", bus.m_addr_o, 32'h0);
      chk("rst_m_we", {31'h0, bus.m_we_o}, 32'h0);
      chk("rst_stall", {31'h0, cpu_stall_o}, 32'h0);
      chk("rst_done_err", {30'h0, cpu_done_o, cpu_err_o}, 32'h0);
      chk("rst_cpu_data", cpu_data_o, 32'h0);
      rst = 1'b1;
      idle(2);

      sel4_cnt = 0;
      run_txn(32'h2000_0010, 1'b0, 32'h0, 32'hCAFE_F00D, 16'h0004, 0, 0);
      idle(1);
      chk("r030_latency", done_cyc - txn_start, 3);
      chk("r030_sel_cycles", sel4_cnt, 2);
      chk("r030_rdata", cpu_data_o, 32'hCAFE_F00D);

      wr80_cnt = 0;
      run_txn(32'h7000_0004, 1'b1, 32'h1234_5678, 32'hDEAD_0000, 16'h0010, 0, 0);
      idle(1);
      chk("r031_wr_cycles", wr80_cnt, 4);
      chk("r031_latency", done_cyc - txn_start, 5);
      chk("r031_rdata_kept", cpu_data_o, 32'hCAFE_F00D);

      run_txn(32'h9000_0000, 1'b0, 32'h0, 32'h1111_2222, 16'hFFFF, 0, 0);
      idle(1);
      chk("r032_err_cycle", err_cyc - txn_start, 1);
      chk("r032_rdata_zero", cpu_data_o, 32'h0);

      run_txn(32'h8000_0000, 1'b1, 32'h5555_0000, 32'h0, 16'h0004, 0, 0);
      idle(1);
      chk("unmapped8_err_cycle", err_cyc - txn_start, 1);

      run_txn(32'h3000_0000, 1'b0, 32'h0, 32'hA5A5_5A5A, 16'h0020, 0, 0);
      idle(1);
      chk("ack_at_limit_done", done_cyc - txn_start, 6);
      chk("ack_at_limit_data", cpu_data_o, 32'hA5A5_5A5A);

      run_txn(32'h1000_0020, 1'b0, 32'h0, 32'h7777_7777, 16'h0002, 0, 0);
      idle(1);
      chk("r033_err_cycle", err_cyc - txn_start, 6);
      chk("r033_rdata_zero", cpu_data_o, 32'h0);

      run_txn(32'h2000_0100, 1'b1, 32'h0F0F_0F0F, 32'h0, 16'h0008, 1, 0);
      idle(1);
      chk("drop_req_done", done_cyc - txn_start, 4);

      run_txn(32'h5000_0100, 1'b0, 32'h0, 32'h5555_0005, 16'h0004, 0, 1);
      d_first = done_cyc;
      run_txn(32'h6000_0200, 1'b0, 32'h0, 32'h6666_0006, 16'h0008, 0, 0);
      idle(1);
      chk("r035_issue_gap", issue_cyc - d_first, 2);
      chk("r035_second_data", cpu_data_o, 32'h6666_0006);

      check_en     = 0;
      cpu_req_i    = 1'b1;
      cpu_addr_i   = 32'h1000_0040;
      cpu_we_i     = 1'b0;
      cpu_data_i   = 32'h0;
      bus.m_ack_i  = 1'b0;
      bus.m_data_i = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      cpu_req_i = 1'b0;
      #2;
      chk("r034_sel_before_rst", {16'h0, bus.m_select_o}, 32'h0000_0002);
      p0 = pulse_cnt;
      #1 rst = 1'b0;
      #1;
      chk("r034_sel_zero", {16'h0, bus.m_select_o}, 32'h0);
      chk("r034_addr_zero", bus.m_addr_o, 32'h0);
      chk("r034_stall_zero", {31'h0, cpu_stall_o}, 32'h0);
      chk("r034_data_zero", cpu_data_o, 32'h0);
      repeat (2) @(posedge clk);
      #3 rst = 1'b1;
      model_rdata = 32'h0;
      bus.m_ack_i = 1'b1;
      @(posedge clk); #1;
      chk("r034_no_pulse", pulse_cnt - p0, 0);
      run_txn(32'h0000_0008, 1'b0, 32'h0, 32'h0BAD_BEEF, 16'h0004, 0, 0);
      idle(1);
      chk("r034_after_done", done_cyc - txn_start, 3);
      chk("r034_after_data", cpu_data_o, 32'h0BAD_BEEF);
      idle(1);

      check_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1, "watchdog");
   end
endmodule
